// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX port among NREQ byte streams.
// A grant is held until a last byte, the burst cap, or an idle timeout.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned MAX_BURST    = 64,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*8-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    output logic [NREQ-1:0]     grant,
    output logic                busy
);

    localparam int unsigned PW  = $clog2(NREQ);
    localparam int unsigned PW1 = PW + 1;
    localparam int unsigned BW  = $clog2(MAX_BURST + 1);
    localparam int unsigned IW  = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [BW-1:0] BurstLast = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BurstMax  = BW'(MAX_BURST);
    localparam logic [IW-1:0] IdleLast  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0] IdleMax   = IW'(IDLE_TIMEOUT);
    localparam logic [PW-1:0] LastIdx   = PW'(NREQ - 1);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic [PW1-1:0]  cand;
    logic            g_valid;
    logic            g_last;
    logic [7:0]      g_data;
    logic            in_xfer;
    logic            xfer;
    logic            release_grant;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + PW1'(k);
            if (cand >= PW1'(NREQ)) begin
                cand = cand - PW1'(NREQ);
            end
            if (!pick_vld && req_valid[cand[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[PW-1:0];
            end
        end
    end

    assign in_xfer = (state_q == StXfer);
    assign g_valid = req_valid[gidx_q];
    assign g_last  = req_last[gidx_q];
    assign g_data  = req_data[{gidx_q, 3'b000} +: 8];
    assign xfer    = in_xfer && g_valid && tx_ready;

    assign release_grant = in_xfer &&
                           ((xfer && (g_last || burst_cnt_q == BurstLast)) ||
                            (!g_valid && idle_cnt_q == IdleLast));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    state_d     = StXfer;
                    gidx_d      = pick_idx;
                    grant_d     = NREQ'(1) << pick_idx;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            StXfer: begin
                if (xfer && burst_cnt_q != BurstMax) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end
                if (g_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IdleMax) begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
                if (release_grant) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    rr_ptr_d = (gidx_q == LastIdx) ? '0 : gidx_q + PW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // Outputs are forced to zero outside XFER so the TX line stays clean.
    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        if (in_xfer) begin
            tx_valid          = g_valid;
            tx_data           = g_data;
            req_ready[gidx_q] = tx_ready;
        end
    end

    assign grant = grant_q;
    assign busy  = in_xfer;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed table-driven bench for uart_tx_arbiter (NREQ=2, MAX_BURST=4, IDLE_TIMEOUT=8).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NREQ        (2),
        .MAX_BURST   (4),
        .IDLE_TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .grant    (grant),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] l;
        logic       r;
        logic [1:0] eg;
        logic       etv;
        logic [7:0] etd;
        logic [1:0] erdy;
        logic       ebusy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [1:0] v, logic [7:0] d0, logic [7:0] d1,
                                logic [1:0] l, logic r, logic [1:0] eg, logic etv,
                                logic [7:0] etd, logic [1:0] erdy);
        vec_t t;
        t.rst = rst; t.v = v; t.d0 = d0; t.d1 = d1; t.l = l; t.r = r;
        t.eg = eg; t.etv = etv; t.etd = etd; t.erdy = erdy; t.ebusy = |eg;
        return t;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, vec_t t);
        chk({tag, " grant"},     {6'd0, grant},     {6'd0, t.eg});
        chk({tag, " tx_valid"},  {7'd0, tx_valid},  {7'd0, t.etv});
        chk({tag, " tx_data"},   tx_data,           t.etd);
        chk({tag, " req_ready"}, {6'd0, req_ready}, {6'd0, t.erdy});
        chk({tag, " busy"},      {7'd0, busy},      {7'd0, t.ebusy});
    endtask

    task automatic drive(vec_t t);
        rst_n     = t.rst;
        req_valid = t.v;
        req_data  = {t.d1, t.d0};
        req_last  = t.l;
        tx_ready  = t.r;
    endtask

    task automatic apply(string tag, vec_t t);
        @(negedge clk);
        drive(t);
        #1;
        check_outs(tag, t);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00));
        // single requester "Hi\n"
        vecs.push_back(mk(1, 2'b01, 8'h48, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b01, 8'h48, 8'h00, 2'b00, 1, 2'b01, 1, 8'h48, 2'b01));
        vecs.push_back(mk(1, 2'b01, 8'h69, 8'h00, 2'b00, 1, 2'b01, 1, 8'h69, 2'b01));
        vecs.push_back(mk(1, 2'b01, 8'h0A, 8'h00, 2'b01, 1, 2'b01, 1, 8'h0A, 2'b01));
        vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        // round-robin, 1-byte messages; rr_ptr=1 so req1 goes first
        vecs.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b11, 1, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b11, 1, 2'b10, 1, 8'hB0, 2'b10));
        vecs.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b11, 1, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b11, 1, 2'b01, 1, 8'hA0, 2'b01));
        vecs.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b11, 1, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b11, 1, 2'b10, 1, 8'hB0, 2'b10));
        vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        // contention from reset: req0 4 bytes, bubble, req1 4 bytes
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b11, 8'h10, 8'h20, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b11, 8'h10, 8'h20, 2'b00, 1, 2'b01, 1, 8'h10, 2'b01));
        vecs.push_back(mk(1, 2'b11, 8'h11, 8'h20, 2'b00, 1, 2'b01, 1, 8'h11, 2'b01));
        vecs.push_back(mk(1, 2'b11, 8'h12, 8'h20, 2'b00, 1, 2'b01, 1, 8'h12, 2'b01));
        vecs.push_back(mk(1, 2'b11, 8'h13, 8'h20, 2'b01, 1, 2'b01, 1, 8'h13, 2'b01));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h20, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h20, 2'b00, 1, 2'b10, 1, 8'h20, 2'b10));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h21, 2'b00, 1, 2'b10, 1, 8'h21, 2'b10));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h22, 2'b00, 1, 2'b10, 1, 8'h22, 2'b10));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h23, 2'b10, 1, 2'b10, 1, 8'h23, 2'b10));
        vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        // burst cap 4: req1 streams 10 bytes, req0 waits with a 1-byte message
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h30, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b11, 8'hC0, 8'h30, 2'b01, 1, 2'b10, 1, 8'h30, 2'b10));
        vecs.push_back(mk(1, 2'b11, 8'hC0, 8'h31, 2'b01, 0, 2'b10, 1, 8'h31, 2'b00));
        vecs.push_back(mk(1, 2'b11, 8'hC0, 8'h31, 2'b01, 1, 2'b10, 1, 8'h31, 2'b10));
        vecs.push_back(mk(1, 2'b11, 8'hC0, 8'h32, 2'b01, 1, 2'b10, 1, 8'h32, 2'b10));
        vecs.push_back(mk(1, 2'b11, 8'hC0, 8'h33, 2'b01, 1, 2'b10, 1, 8'h33, 2'b10));
        vecs.push_back(mk(1, 2'b11, 8'hC0, 8'h34, 2'b01, 1, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b11, 8'hC0, 8'h34, 2'b01, 1, 2'b01, 1, 8'hC0, 2'b01));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h34, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h34, 2'b00, 1, 2'b10, 1, 8'h34, 2'b10));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h35, 2'b00, 1, 2'b10, 1, 8'h35, 2'b10));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h36, 2'b00, 1, 2'b10, 1, 8'h36, 2'b10));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h37, 2'b00, 1, 2'b10, 1, 8'h37, 2'b10));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h38, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h38, 2'b00, 1, 2'b10, 1, 8'h38, 2'b10));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h39, 2'b10, 1, 2'b10, 1, 8'h39, 2'b10));
        vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure then idle timeout: tx_ready 0-1, then 8 idle cycles with req1 waiting.
        apply("to_arb",  mk(1, 2'b01, 8'h55, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        apply("to_bp",   mk(1, 2'b01, 8'h55, 8'h00, 2'b00, 0, 2'b01, 1, 8'h55, 2'b00));
        apply("to_xfer", mk(1, 2'b01, 8'h55, 8'h00, 2'b00, 1, 2'b01, 1, 8'h55, 2'b01));
        for (int k = 0; k < 8; k++) begin
            logic r;
            r = (k % 2 == 0);
            apply($sformatf("to_idle%0d", k),
                  mk(1, 2'b10, 8'h00, 8'h66, 2'b10, r, 2'b01, 0, 8'h00, {1'b0, r}));
        end
        apply("to_bubble", mk(1, 2'b10, 8'h00, 8'h66, 2'b10, 1, 2'b00, 0, 8'h00, 2'b00));
        apply("to_req1",   mk(1, 2'b10, 8'h00, 8'h66, 2'b10, 1, 2'b10, 1, 8'h66, 2'b10));
        apply("to_done",   mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));

        // Reset asserted during the second byte of a req0 burst.
        apply("rst_arb",   mk(1, 2'b01, 8'h70, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        apply("rst_byte1", mk(1, 2'b01, 8'h70, 8'h00, 2'b00, 1, 2'b01, 1, 8'h70, 2'b01));
        apply("rst_byte2", mk(1, 2'b01, 8'h71, 8'h00, 2'b00, 1, 2'b01, 1, 8'h71, 2'b01));
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", mk(0, 2'b01, 8'h71, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        apply("rst_hold",  mk(0, 2'b11, 8'h71, 8'h80, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        apply("rst_rel",   mk(1, 2'b11, 8'h71, 8'h80, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
        apply("rst_regnt", mk(1, 2'b11, 8'h71, 8'h80, 2'b00, 1, 2'b01, 1, 8'h71, 2'b01));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter between `NREQ` byte-stream requesters, for example the core's UART0 driver and a debug/trace source, inside `arty_a7_shell`. A grant is held for a whole message, so bytes from different requesters never interleave on `uart_txd`. A message ends on a `last`-flagged byte, a burst-length cap, or an idle timeout. The block sits between the requesters and the UART TX core, using valid/ready handshakes on both sides.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `MAX_BURST`, 64: maximum bytes per grant, ≥1.
- `IDLE_TIMEOUT`, 1024: consecutive cycles the granted requester may hold `req_valid` low before the grant is revoked, ≥1.

- `clk` input 1: single clock (100 MHz at top level).
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: per-requester byte valid.
- `req_data` input NREQ*8: byte of requester i at `[8*i+7:8*i]`.
- `req_last` input NREQ: byte is the last of its message.
- `req_ready` output NREQ: byte accepted this cycle.
- `tx_valid` output 1: byte offered to the UART TX core.
- `tx_data` output 8: byte to transmit.
- `tx_ready` input 1: UART TX core accepts the byte.
- `grant` output NREQ: one-hot current owner, all-zero when idle.
- `busy` output 1: high in XFER.

## Operation
- FSM has two states.
  - IDLE: `grant`=0, `tx_valid`=0, `req_ready`=0.
  - XFER: requester `g` owns the TX port.
- Arbitration (IDLE): if any `req_valid` is set, pick the first set index searching from `rr_ptr` upward, wrapping modulo NREQ. On the next edge: load `grant`, go to XFER, clear `burst_cnt` and `idle_cnt`.
- XFER datapath (combinational through the granted lane):
  - `tx_valid` = `req_valid[g]`
  - `tx_data` = `req_data[g]`
  - `req_ready[g]` = `tx_ready`
  - all other `req_ready` bits = 0.
- A transfer is `tx_valid && tx_ready`. On each transfer, `burst_cnt` increments. Width is `$clog2(MAX_BURST+1)`; the counter saturates and never wraps.
- Release conditions, evaluated at the edge:
  - a transfer with `req_last[g]`=1;
  - or a transfer with `burst_cnt` == MAX_BURST-1;
  - or `idle_cnt` == IDLE_TIMEOUT-1 while `req_valid[g]`=0.
- On release: go to IDLE, `grant`←0, `rr_ptr` ← (g+1) mod NREQ.
- `idle_cnt` increments each XFER cycle with `req_valid[g]`=0 and clears on any cycle with `req_valid[g]`=1.
- Non-granted requesters stall (`req_ready`=0) and keep their data stable per valid/ready rules. The arbiter never drops a byte.
- A release by timeout or burst cap does not discard state. The requester re-arbitrates normally and continues its message.
- `tx_ready` asserted while `tx_valid`=0 has no effect.

## Timing
- Reset (asynchronous assert, synchronous deassert at the top level) values:
  - state=IDLE, `grant`=0, `rr_ptr`=0, counters=0;
  - `busy`=0, `tx_valid`=0, `tx_data`=0, `req_ready`=0.
- Latency:
  - `req_valid` rising in IDLE → `grant`/`tx_valid` high on the following cycle (1-cycle arbitration).
  - Byte handoff in XFER is 0-cycle (combinational).
- Bubble: exactly one IDLE cycle between consecutive grants, even when other requesters are waiting.
- Simultaneous release and new request: the request is evaluated in the IDLE cycle using the updated `rr_ptr`.
- Reset mid-XFER: the grant is dropped immediately (asynchronous). The byte in flight is considered not accepted unless `tx_ready` was sampled before reset.
- `tx_data` outside XFER is 0 (not X), so the monitor-friendly UART bench sees clean lines.

## Test plan
- Single requester: req0 sends "Hi\n" (0x48, 0x69, 0x0A with last on 0x0A), `tx_ready` always 1. Required: 3 transfers on consecutive cycles after 1 arbitration cycle; `grant`=01 for exactly 3 cycles, then IDLE; `rr_ptr`=1.
- Contention: req0 and req1 both valid from reset release, each sending a 4-byte message with last on byte 4. Required: req0 is served first (`rr_ptr`=0), 1 bubble cycle, then req1; no interleaving on `tx_data`.
- Round-robin fairness: both requesters continuously send 1-byte messages. Required: `grant` alternates 01,10,01,10…, and each owner accepts exactly 1 byte per grant.
- Burst cap: MAX_BURST=4, req1 streams 10 bytes with no last and req0 waiting. Required: req1 4 bytes, req0 message, req1 4 bytes, and so on; `burst_cnt` never exceeds 4.
- Backpressure and timeout: IDLE_TIMEOUT=8. req0 sends 1 byte without last, then drops valid; `tx_ready` toggles 1-0-1. Required: no transfer while `tx_ready`=0; grant is released exactly 8 cycles after valid drops; req1 is then granted.
- Reset mid-message: assert `rst_n`=0 during the second byte of a 5-byte req0 burst. Required: `grant`, `tx_valid`, `req_ready`, `busy` go to 0 without a clock edge; after release, `rr_ptr`=0 and arbitration restarts cleanly.
